// File: rtl/mult32x32_req_if_if.sv
// Request, multiplier-core and result-stream signals of the multiplier front end.
// The front end uses the slave modport; the driving environment uses master.
interface mult32x32_req_if_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             mul_start;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_busy;
    logic [63:0]      mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_product;
    logic [TAG_W-1:0] out_tag;
    logic             err_proto;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, mul_busy, mul_product, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_product, out_tag, err_proto
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, mul_busy, mul_product, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_product, out_tag, err_proto
    );
endinterface

// File: rtl/mult32x32_req_if.sv
// Front end for the sequential 32x32 multiplier: latches operands, pulses start, checks busy and queues tagged products.
// Result visible 11 cycles after accept for a core busy 8 cycles; in_ready drops while an op is in flight or the result FIFO is full.
module mult32x32_req_if_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = wr_vld && (cnt_q != CW'(DEPTH));
        do_pop   = rd_rdy && (cnt_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_vld = (cnt_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = cnt_q;
endmodule

module mult32x32_req_if #(
    parameter int TAG_W     = 4,
    parameter int RES_DEPTH = 2,
    parameter int BUSY_MAX  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mult32x32_req_if_if.slave    bus
);
    localparam int BW = $clog2(BUSY_MAX + 1);
    localparam int CW = $clog2(RES_DEPTH) + 1;
    localparam int RW = 64 + TAG_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             accept, busy_ovf, never_busy, push;
    logic [CW-1:0]    fifo_cnt;
    logic [RW-1:0]    head_dat;

    assign accept     = bus.in_valid && bus.in_ready;
    // Busy still high once the counter is saturated means the core overran its budget.
    assign busy_ovf   = (state_q == RUN) && bus.mul_busy && (cnt_q == BW'(BUSY_MAX));
    assign never_busy = (state_q == RUN) && !bus.mul_busy && (cnt_q == '0);
    assign push       = (state_q == RUN) && !bus.mul_busy && (cnt_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = RUN;
            RUN:     if (!bus.mul_busy || busy_ovf) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mul_start = (state_q == START);
        bus.in_ready  = (state_q == IDLE) && (fifo_cnt < CW'(RES_DEPTH));
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        tag_d = tag_q;
        cnt_d = cnt_q;
        err_d = err_q || busy_ovf || never_busy;
        if (accept) begin
            a_d   = bus.in_a;
            b_d   = bus.in_b;
            tag_d = bus.in_tag;
        end
        if (state_q == START) begin
            cnt_d = '0;
        end else if ((state_q == RUN) && bus.mul_busy && !busy_ovf) begin
            cnt_d = cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            tag_q <= tag_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    mult32x32_req_if_fifo #(
        .W     (RW),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (push),
        .wr_dat ({bus.mul_product, tag_q}),
        .rd_vld (bus.out_valid),
        .rd_rdy (bus.out_ready),
        .rd_dat (head_dat),
        .count  (fifo_cnt)
    );

    assign bus.mul_a       = a_q;
    assign bus.mul_b       = b_q;
    assign bus.out_product = head_dat[RW-1:TAG_W];
    assign bus.out_tag     = head_dat[TAG_W-1:0];
    assign bus.err_proto   = err_q;
endmodule

// File: tb/tb_mult32x32_req_if.sv
// Randomized and directed bench for mult32x32_req_if with a behavioural core model and result scoreboard.
module tb_mult32x32_req_if;
    logic clk;
    logic reset;

    mult32x32_req_if_if #(.TAG_W(4)) bus ();

    mult32x32_req_if #(.TAG_W(4), .RES_DEPTH(2), .BUSY_MAX(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] p;
        logic [3:0]  t;
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   rand_rdy = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Core stand-in: after a start pulse, busy for the requested number of cycles, product ready at start.
    initial begin : core_model
        bit st;
        int rem;
        rem = 0;
        bus.mul_busy    = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(negedge clk);
            st = bus.mul_start;
            @(posedge clk);
            #1;
            if (reset) begin
                rem = 0;
            end else if (st) begin
                rem = (len_q.size() != 0) ? len_q.pop_front() : 8;
                bus.mul_product = {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
            end
            bus.mul_busy = (rem > 0);
            if (rem > 0) rem--;
        end
    end

    initial begin : rdy_driver
        forever begin
            @(negedge clk);
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard: every pop must match the oldest outstanding completed request.
    initial begin : consumer
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
                end else if (bus.out_valid && bus.out_ready) begin
                    e = exp_q.pop_front();
                    chk("out_product", bus.out_product, e.p);
                    chk("out_tag", 64'(bus.out_tag), 64'(e.t));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Returns in the cycle after the accepting edge (mul_start cycle).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
                        input int blen, input logic [63:0] p);
        bit   done;
        exp_t e;
        done         = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tg;
        for (int k = 0; k < 300 && !done; k++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                done = 1;
                len_q.push_back(blen);
                if (blen >= 1 && blen <= 8) begin
                    e.p = p;
                    e.t = tg;
                    exp_q.push_back(e);
                end
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("accept_in_time", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_in_ready"},    64'(bus.in_ready), 64'd1);
        chk({pfx, "_mul_start"},   64'(bus.mul_start), 64'd0);
        chk({pfx, "_mul_a"},       64'(bus.mul_a), 64'd0);
        chk({pfx, "_mul_b"},       64'(bus.mul_b), 64'd0);
        chk({pfx, "_out_valid"},   64'(bus.out_valid), 64'd0);
        chk({pfx, "_out_product"}, bus.out_product, 64'd0);
        chk({pfx, "_out_tag"},     64'(bus.out_tag), 64'd0);
        chk({pfx, "_err_proto"},   64'(bus.err_proto), 64'd0);
    endtask

    initial begin : main
        int          n, extra, hi;
        logic [31:0] a, b;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        cyc(3);
        reset_checks("rst");
        reset = 1'b0;
        cyc(2);

        // Basic latency: 3*5, result at T+11, one-cycle start pulse.
        bus.out_ready = 1'b1;
        send(32'd3, 32'd5, 4'd1, 8, 64'd15);
        chk("start_high_T1", 64'(bus.mul_start), 64'd1);
        n = 1;
        extra = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.mul_start) extra++;
        end
        chk("out_valid_latency", 64'(n), 64'd11);
        chk("start_single_cycle", 64'(extra), 64'd0);
        drain();

        // Corner operands.
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 8, 64'hFFFF_FFFE_0000_0001);
        send(32'h1234_5678, 32'd0, 4'd3, 8, 64'd0);
        drain();

        // Backpressure: two results fill the FIFO, third request must wait for a pop.
        bus.out_ready = 1'b0;
        send(32'd10, 32'd11, 4'd1, 8, 64'd110);
        send(32'd20, 32'd21, 4'd2, 8, 64'd420);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'd30;
        bus.in_b     = 32'd31;
        bus.in_tag   = 4'd3;
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) hi++;
        end
        chk("bp_in_ready_low", 64'(hi), 64'd0);
        chk("bp_head_tag", 64'(bus.out_tag), 64'd1);
        bus.out_ready = 1'b1;
        send(32'd30, 32'd31, 4'd3, 8, 64'd930);
        drain();

        // Operands wiggle during the operation; held operands must not move.
        send(32'hDEAD_BEEF, 32'h0000_1234, 4'd7, 8, 64'hDEAD_BEEF * 64'h1234);
        for (int k = 0; k < 40 && !bus.out_valid; k++) begin
            @(negedge clk);
            bus.in_a = $urandom;
            bus.in_b = $urandom;
            chk("hold_mul_a", 64'(bus.mul_a), 64'hDEAD_BEEF);
            chk("hold_mul_b", 64'(bus.mul_b), 64'h0000_1234);
        end
        drain();

        // Core never raises busy.
        send(32'd4, 32'd4, 4'd4, 0, 64'd16);
        @(negedge clk);
        chk("err_T2", 64'(bus.err_proto), 64'd0);
        @(negedge clk);
        chk("err_T3", 64'(bus.err_proto), 64'd1);
        cyc(12);
        chk("err0_no_out", 64'(bus.out_valid), 64'd0);

        // Busy held one cycle too long.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("err_cleared", 64'(bus.err_proto), 64'd0);
        send(32'd6, 32'd6, 4'd5, 9, 64'd36);
        cyc(11);
        chk("err_busy_ovf", 64'(bus.err_proto), 64'd1);
        chk("ovf_in_ready", 64'(bus.in_ready), 64'd1);
        chk("ovf_no_out", 64'(bus.out_valid), 64'd0);
        send(32'd7, 32'd9, 4'd5, 8, 64'd63);
        drain();
        chk("err_sticky", 64'(bus.err_proto), 64'd1);

        // Reset in the middle of an operation.
        send(32'h0000_ABCD, 32'h0000_1234, 4'd6, 8, 64'hABCD * 64'h1234);
        cyc(4);
        reset = 1'b1;
        #1;
        reset_checks("midrst");
        exp_q.delete();
        len_q.delete();
        @(negedge clk);
        reset = 1'b0;
        cyc(15);
        chk("midrst_no_out", 64'(bus.out_valid), 64'd0);
        send(32'd100, 32'd200, 4'd9, 8, 64'd20000);
        drain();

        // Random traffic with random consumer stalls and core latencies.
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0:       a = 32'hFFFF_FFFF;
                1:       b = 32'd0;
                2:       b = 32'hFFFF_FFFF;
                default: ;
            endcase
            send(a, b, 4'($urandom), int'($urandom_range(1, 8)), {32'b0, a} * {32'b0, b});
        end
        rand_rdy = 0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drain();
        chk("final_err_clear", 64'(bus.err_proto), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
